prbs_link_test_ctrl: RTL and testbench



---
 rtl/prbs_ctrl_pkg.sv | 21 ++
 rtl/prbs_link_test_ctrl_sat_counter.sv | 35 +++
 rtl/prbs_link_test_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_prbs_link_test_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_ctrl_pkg.sv
// Shared definitions for the PRBS7 link test sequencer: state encoding and
// default parameter values also used by the host readout map.
package prbs_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_LINK = 3'd1,
    ST_WAIT_ALIGN = 3'd2,
    ST_SETTLE     = 3'd3,
    ST_MEASURE    = 3'd4,
    ST_DONE       = 3'd5
  } ctrl_state_e;

  localparam int RST_PULSE_DEF     = 8;
  localparam int ALIGN_TIMEOUT_DEF = 4096;
  localparam int SETTLE_CYCLES_DEF = 64;
  localparam int MAX_RETRIES_DEF   = 3;
  localparam int WC_W_DEF          = 32;
  localparam int EC_W_DEF          = 16;

endpackage

// File: rtl/prbs_link_test_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment and the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prbs_link_test_ctrl.sv
// PRBS7 link bit-error test sequencer: aligner reset, lock wait, settle, then a
// bounded measurement window. Define PRBS_CTRL_RELOCK_EN to retry on lock loss
// during measurement instead of failing immediately.
module prbs_link_test_ctrl
  import prbs_ctrl_pkg::*;
#(
  parameter int RST_PULSE     = RST_PULSE_DEF,
  parameter int ALIGN_TIMEOUT = ALIGN_TIMEOUT_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int MAX_RETRIES   = MAX_RETRIES_DEF,
  parameter int WC_W          = WC_W_DEF,
  parameter int EC_W          = EC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [WC_W-1:0] measure_len,
  input  logic [EC_W-1:0] err_threshold,
  input  logic            aligned,
  input  logic            errorFlag,
  output logic            align_reset,
  output logic            check_enable,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout_flag,
  output logic            link_lost,
  output logic [2:0]      state,
  output logic [WC_W-1:0] word_count,
  output logic [EC_W-1:0] error_count,
  output logic [1:0]      retry_count
);

  localparam int TMR_MAX = (ALIGN_TIMEOUT > SETTLE_CYCLES)
                         ? ((ALIGN_TIMEOUT > RST_PULSE) ? ALIGN_TIMEOUT : RST_PULSE)
                         : ((SETTLE_CYCLES > RST_PULSE) ? SETTLE_CYCLES : RST_PULSE);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_PULSE - 1);
  localparam logic [TMR_W-1:0] ALIGN_LAST  = TMR_W'(ALIGN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  ctrl_state_e     state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [WC_W-1:0] word_count_q, word_count_d;
  logic [WC_W-1:0] len_q, len_d;
  logic [EC_W-1:0] thr_q, thr_d;
  logic [1:0]      retry_count_q, retry_count_d;
  logic            pass_q, pass_d;
  logic            timeout_flag_q, timeout_flag_d;
  logic            link_lost_q, link_lost_d;
  logic            align_reset_q, align_reset_d;
  logic            check_enable_q, check_enable_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            err_clr;
  logic            err_inc;
  logic            retry_req;
  logic            retry_link;
  logic [EC_W-1:0] err_final;

  sat_counter #(.W(EC_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (err_clr),
    .inc   (err_inc),
    .count (error_count)
  );

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    word_count_d   = word_count_q;
    len_d          = len_q;
    thr_d          = thr_q;
    retry_count_d  = retry_count_q;
    pass_d         = pass_q;
    timeout_flag_d = timeout_flag_q;
    link_lost_d    = link_lost_q;
    err_clr        = 1'b0;
    err_inc        = 1'b0;
    retry_req      = 1'b0;
    retry_link     = 1'b0;
    // Error total including this cycle's word, needed for the same-cycle verdict.
    err_final      = (errorFlag && (error_count != '1)) ? error_count + EC_W'(1) : error_count;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          len_d          = measure_len;
          thr_d          = err_threshold;
          word_count_d   = '0;
          retry_count_d  = '0;
          pass_d         = 1'b0;
          timeout_flag_d = 1'b0;
          link_lost_d    = 1'b0;
          err_clr        = 1'b1;
          timer_d        = '0;
          state_d        = ST_RESET_LINK;
        end
      end
      ST_RESET_LINK: begin
        if (timer_q == RST_LAST) begin
          timer_d = '0;
          state_d = ST_WAIT_ALIGN;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WAIT_ALIGN: begin
        if (aligned) begin
          timer_d = '0;
          state_d = ST_SETTLE;
        end else if (timer_q == ALIGN_LAST) begin
          retry_req = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_SETTLE: begin
        if (!aligned) begin
          retry_req = 1'b1;
        end else if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          if (len_q == '0) begin
            pass_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_MEASURE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        if (!aligned) begin
`ifdef PRBS_CTRL_RELOCK_EN
          retry_req  = 1'b1;
          retry_link = 1'b1;
`else
          pass_d      = 1'b0;
          link_lost_d = 1'b1;
          state_d     = ST_DONE;
`endif
        end else begin
          word_count_d = word_count_q + WC_W'(1);
          err_inc      = errorFlag;
          if (word_count_q == len_q - WC_W'(1)) begin
            pass_d  = (err_final <= thr_q);
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (retry_req) begin
      if (retry_count_q < RETRY_MAX) begin
        retry_count_d = retry_count_q + 2'd1;
        word_count_d  = '0;
        err_clr       = 1'b1;
        timer_d       = '0;
        state_d       = ST_RESET_LINK;
      end else begin
        pass_d  = 1'b0;
        state_d = ST_DONE;
        if (retry_link) begin
          link_lost_d = 1'b1;
        end else begin
          timeout_flag_d = 1'b1;
        end
      end
    end

    if (abort) begin
      state_d        = ST_IDLE;
      timer_d        = '0;
      word_count_d   = '0;
      len_d          = '0;
      thr_d          = '0;
      retry_count_d  = '0;
      pass_d         = 1'b0;
      timeout_flag_d = 1'b0;
      link_lost_d    = 1'b0;
      err_clr        = 1'b1;
      err_inc        = 1'b0;
    end

    align_reset_d  = (state_d == ST_RESET_LINK);
    check_enable_d = (state_d == ST_MEASURE);
    busy_d         = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d         = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      word_count_q   <= '0;
      len_q          <= '0;
      thr_q          <= '0;
      retry_count_q  <= '0;
      pass_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
      link_lost_q    <= 1'b0;
      align_reset_q  <= 1'b0;
      check_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      word_count_q   <= word_count_d;
      len_q          <= len_d;
      thr_q          <= thr_d;
      retry_count_q  <= retry_count_d;
      pass_q         <= pass_d;
      timeout_flag_q <= timeout_flag_d;
      link_lost_q    <= link_lost_d;
      align_reset_q  <= align_reset_d;
      check_enable_q <= check_enable_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign state        = state_q;
  assign word_count   = word_count_q;
  assign retry_count  = retry_count_q;
  assign pass         = pass_q;
  assign timeout_flag = timeout_flag_q;
  assign link_lost    = link_lost_q;
  assign align_reset  = align_reset_q;
  assign check_enable = check_enable_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_prbs_link_test_ctrl.sv
// Scoreboard bench for prbs_link_test_ctrl: stimulus pushes expected verdicts,
// a negedge monitor pops and compares them when done rises.
module tb_prbs_link_test_ctrl;

  localparam int RP = 8;
  localparam int AT = 512;
  localparam int SC = 64;
  localparam int LD = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] measure_len = '0;
  logic [15:0] err_threshold = '0;
  logic        aligned = 1'b0;
  logic        errorFlag = 1'b0;
  logic        align_reset, check_enable, busy, done, pass, timeout_flag, link_lost;
  logic [2:0]  state;
  logic [31:0] word_count;
  logic [15:0] error_count;
  logic [1:0]  retry_count;

  typedef struct {
    int              id;
    logic            pass;
    logic            to;
    logic            ll;
    longint unsigned wc;
    longint unsigned ec;
    longint unsigned rc;
    int              pulses;
    int              cycles;
    int              start_cyc;
    int              deadline;
  } exp_t;

  exp_t  sb[$];
  string idle_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  // Aligner/checker model configuration, written only by the stimulus process.
  int lock_delay = LD;
  int drop_at = -1;
  int ew0 = -1, ew1 = -1, ew2 = -1;
  bit err_all = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shortened alignment timeout keeps the exhausted-retry run brief.
  prbs_link_test_ctrl #(
    .RST_PULSE(RP), .ALIGN_TIMEOUT(AT), .SETTLE_CYCLES(SC),
    .MAX_RETRIES(3), .WC_W(32), .EC_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .measure_len(measure_len), .err_threshold(err_threshold),
    .aligned(aligned), .errorFlag(errorFlag),
    .align_reset(align_reset), .check_enable(check_enable), .busy(busy),
    .done(done), .pass(pass), .timeout_flag(timeout_flag), .link_lost(link_lost),
    .state(state), .word_count(word_count), .error_count(error_count),
    .retry_count(retry_count)
  );

  int lock_cnt = 0;
  bit dropped = 1'b0;

  // Aligner locks lock_delay cycles after align_reset drops; checker flags listed words.
  always @(negedge clk) begin
    if (!busy) dropped = 1'b0;
    if (reset || align_reset) begin
      lock_cnt = 0;
      aligned  = 1'b0;
    end else if (!dropped && drop_at >= 0 && check_enable && int'(word_count) == drop_at) begin
      aligned  = 1'b0;
      dropped  = 1'b1;
      lock_cnt = 0;
    end else if (lock_cnt < lock_delay) begin
      lock_cnt = lock_cnt + 1;
      aligned  = (lock_cnt == lock_delay);
    end
    errorFlag = check_enable && (err_all || int'(word_count) == ew0 ||
                                 int'(word_count) == ew1 || int'(word_count) == ew2);
  end

  task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned expv);
    vectors = vectors + 1;
    if (act !== expv) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  logic done_prev = 1'b0, busy_prev = 1'b0, ar_prev = 1'b0;
  int   pulses = 0, bad_w = 0, cur_w = 0;

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (busy && !busy_prev) begin
      pulses = 0;
      bad_w  = 0;
      cur_w  = 0;
    end
    if (align_reset) begin
      cur_w = cur_w + 1;
    end else if (ar_prev) begin
      pulses = pulses + 1;
      if (cur_w != RP) bad_w = bad_w + 1;
      cur_w = 0;
    end
    if (idle_q.size() > 0) begin
      nm = idle_q.pop_front();
      checkOutput({nm, "_ctrl"}, 64'({state, align_reset, check_enable, busy, done,
                                      pass, timeout_flag, link_lost, retry_count}), 64'd0);
      checkOutput({nm, "_word_count"}, 64'(word_count), 64'd0);
      checkOutput({nm, "_error_count"}, 64'(error_count), 64'd0);
    end
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("run%0d_pass", e.id), 64'(pass), 64'(e.pass));
        checkOutput($sformatf("run%0d_timeout_flag", e.id), 64'(timeout_flag), 64'(e.to));
        checkOutput($sformatf("run%0d_link_lost", e.id), 64'(link_lost), 64'(e.ll));
        checkOutput($sformatf("run%0d_word_count", e.id), 64'(word_count), e.wc);
        checkOutput($sformatf("run%0d_error_count", e.id), 64'(error_count), e.ec);
        checkOutput($sformatf("run%0d_retry_count", e.id), 64'(retry_count), e.rc);
        checkOutput($sformatf("run%0d_state_busy", e.id), 64'({state, busy, check_enable, align_reset}), 64'({3'd5, 3'b000}));
        checkOutput($sformatf("run%0d_pulses", e.id), 64'(pulses), 64'(e.pulses));
        checkOutput($sformatf("run%0d_pulse_width", e.id), 64'(bad_w), 64'd0);
        checkOutput($sformatf("run%0d_latency", e.id), 64'(cyc - e.start_cyc), 64'(e.cycles));
      end
    end else if (sb.size() > 0 && cyc > sb[0].deadline) begin
      e = sb.pop_front();
      checkOutput($sformatf("run%0d_done_timeout", e.id), 64'd0, 64'd1);
    end
    done_prev = done;
    busy_prev = busy;
    ar_prev   = align_reset;
  end

  task automatic applyStimulus(input int id, input int len, input int thr, input int ldly,
                               input int drop, input int w0, input int w1, input int w2,
                               input bit all, input bit xpass, input bit xto, input bit xll,
                               input longint unsigned xwc, input longint unsigned xec,
                               input longint unsigned xrc, input int xpulses, input int xcycles);
    exp_t e;
    @(negedge clk);
    lock_delay    = ldly;
    drop_at       = drop;
    ew0           = w0;
    ew1           = w1;
    ew2           = w2;
    err_all       = all;
    measure_len   = 32'(len);
    err_threshold = 16'(thr);
    e.id = id; e.pass = xpass; e.to = xto; e.ll = xll;
    e.wc = xwc; e.ec = xec; e.rc = xrc; e.pulses = xpulses; e.cycles = xcycles;
    e.start_cyc = cyc + 1;
    e.deadline  = cyc + 1 + xcycles + 50;
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the inputs to prove they were latched at start.
    measure_len   = 32'd7;
    err_threshold = 16'hFFFF;
    for (int i = 0; i < xcycles + 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      $display("[TB] FAIL run%0d: scoreboard entry never retired", id);
      $fatal(1, "[TB] stopping");
    end
    repeat (5) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_q.push_back("reset");
    repeat (30) @(posedge clk);

    // Clean run, then three error words (one on the last word) at two thresholds.
    applyStimulus(1, 1000, 0, LD, -1, -1, -1, -1, 0, 1, 0, 0, 1000, 0, 0, 1, RP + LD + SC + 1000);
    applyStimulus(2, 1000, 2, LD, -1, 10, 500, 999, 0, 0, 0, 0, 1000, 3, 0, 1, RP + LD + SC + 1000);
    applyStimulus(3, 1000, 3, LD, -1, 10, 500, 999, 0, 1, 0, 0, 1000, 3, 0, 1, RP + LD + SC + 1000);
    applyStimulus(4, 0, 0, LD, -1, -1, -1, -1, 0, 1, 0, 0, 0, 0, 0, 1, RP + LD + SC);
    applyStimulus(5, 1000, 0, 1000000, -1, -1, -1, -1, 0, 0, 1, 0, 0, 0, 3, 4, 4 * (RP + AT));
`ifdef PRBS_CTRL_RELOCK_EN
    applyStimulus(6, 1000, 1, LD, 500, 500, -1, -1, 0, 1, 0, 0, 1000, 1, 1, 2,
                  (RP + LD + SC + 501) + (RP + LD + SC + 1000));
`else
    applyStimulus(6, 1000, 1, LD, 500, 500, -1, -1, 0, 0, 0, 1, 500, 0, 0, 1, RP + LD + SC + 501);
`endif
    applyStimulus(7, 65540, 65535, LD, -1, -1, -1, -1, 1, 1, 0, 0, 65540, 65535, 0, 1, RP + LD + SC + 65540);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    idle_q.push_back("abort_with_start");
    repeat (5) @(posedge clk);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    idle_q.push_back("abort_mid_pulse");
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
